// File: rtl/ldpc_cw_loader.sv
// ldpc_cw_loader: pulls one codeword of soft values from bidin per request burst into a local buffer and hands it to the LDPC core.
// Latency: ldpc_req rises 1 cycle after bidin_rdy is seen in IDLE; ldpc_fin rises 1 cycle after dec_done; buffer read is 1 cycle.
// Backpressure: no stall towards bidin; new bursts wait for dec_done, surplus samples are dropped and flagged in err_ovf.
// Optional build macro LDPC_LOAD_TMO_EN: DRAIN gives up after 64 cycles and zero-fills the missing samples.
module ldpc_cw_loader #(
   parameter int WID        = 6,
   parameter int CW_LEN     = 9216,
   parameter int CW_PER_FRM = 15,
   parameter int AW         = 14,
   parameter int GAP_CYC    = 2
) (
   input  logic           clk6,
   input  logic           rst,
   input  logic           bidin_rdy,
   input  logic           bidin_ena_out,
   input  logic [WID-1:0] bidin_dout,
   output logic           ldpc_req,
   output logic           ldpc_fin,
   input  logic [AW-1:0]  dec_rd_addr,
   output logic [WID-1:0] dec_rd_data,
   output logic           cw_valid,
   input  logic           dec_done,
   output logic [3:0]     cw_idx,
   output logic           frm_done,
   output logic           err_ovf
);

   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [AW-1:0] CW_FULL  = AW'(CW_LEN);
   localparam logic [AW-1:0] LAST_REQ = AW'(CW_LEN - 1);
   localparam logic [3:0]    LAST_CW  = 4'(CW_PER_FRM - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      DRAIN  = 3'd2,
      DECODE = 3'd3,
      FIN    = 3'd4,
      GAP    = 3'd5
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [AW-1:0]   req_cnt;
   logic [AW-1:0]   wr_cnt;
   logic [GW-1:0]   gap_cnt;
   logic            frm_start;
   logic            next_cw;
   logic            frm_end;
   logic            cw_full;
   logic            smp_ok;
   logic            wr_en;
   logic [WID-1:0]  wr_dat;
   logic            ovf_set;
   logic [WID-1:0]  cw_buf [0:(1<<AW)-1];

`ifdef LDPC_LOAD_TMO_EN
   logic [6:0]      tmo_cnt;
   logic            fill;
`endif

   // State register; reset forces IDLE so req/fin/valid fall immediately
   always_ff @(posedge clk6 or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and state-derived handshake outputs
   always_comb begin
      state_nxt = state;
      ldpc_req  = 1'b0;
      ldpc_fin  = 1'b0;
      cw_valid  = 1'b0;
      frm_start = 1'b0;
      next_cw   = 1'b0;
      frm_end   = 1'b0;
      case (state)
         IDLE: begin
            if (bidin_rdy) begin
               frm_start = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            ldpc_req = 1'b1;
            if (req_cnt == LAST_REQ) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (cw_full) begin
               state_nxt = DECODE;
            end
         end
         DECODE: begin
            cw_valid = 1'b1;
            if (dec_done) begin
               state_nxt = FIN;
            end
         end
         FIN: begin
            ldpc_fin  = 1'b1;
            state_nxt = GAP;
         end
         GAP: begin
            if (gap_cnt == LAST_GAP) begin
               if (cw_idx == LAST_CW) begin
                  frm_end   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  next_cw   = 1'b1;
                  state_nxt = REQ;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cw_full = (wr_cnt == CW_FULL);

   // Sample acceptance: only while a burst is outstanding and the buffer has room
`ifdef LDPC_LOAD_TMO_EN
   assign fill    = (state == DRAIN) && tmo_cnt[6] && !cw_full;
   assign smp_ok  = bidin_ena_out && ((state == REQ) || (state == DRAIN)) && !cw_full && !fill;
   assign wr_en   = smp_ok || fill;
   assign wr_dat  = fill ? '0 : bidin_dout;
   assign ovf_set = (bidin_ena_out && !smp_ok) || fill;
`else
   assign smp_ok  = bidin_ena_out && ((state == REQ) || (state == DRAIN)) && !cw_full;
   assign wr_en   = smp_ok;
   assign wr_dat  = bidin_dout;
   assign ovf_set = bidin_ena_out && !smp_ok;
`endif

   // Burst, gap and codeword counters plus the end-of-frame pulse
   always_ff @(posedge clk6 or posedge rst) begin
      if (rst) begin
         req_cnt  <= '0;
         gap_cnt  <= '0;
         cw_idx   <= '0;
         frm_done <= 1'b0;
      end else begin
         frm_done <= frm_end;
         if (frm_start || next_cw) begin
            req_cnt <= '0;
         end else if (state == REQ) begin
            req_cnt <= req_cnt + 1'b1;
         end
         if (state == GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end
         if (frm_start || frm_end) begin
            cw_idx <= '0;
         end else if (next_cw) begin
            cw_idx <= cw_idx + 1'b1;
         end
      end
   end

   // Write pointer and sticky overflow flag
   always_ff @(posedge clk6 or posedge rst) begin
      if (rst) begin
         wr_cnt  <= '0;
         err_ovf <= 1'b0;
      end else begin
         if (frm_start || next_cw) begin
            wr_cnt <= '0;
         end else if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
         end
         if (ovf_set) begin
            err_ovf <= 1'b1;
         end
      end
   end

`ifdef LDPC_LOAD_TMO_EN
   // DRAIN watchdog: counts up to 64 from the cycle ldpc_req falls, then holds
   always_ff @(posedge clk6 or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state != DRAIN) begin
         tmo_cnt <= '0;
      end else if (!tmo_cnt[6]) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`endif

   // Codeword buffer write port; contents are deliberately not reset
   always_ff @(posedge clk6) begin
      if (wr_en) begin
         cw_buf[wr_cnt] <= wr_dat;
      end
   end

   // Decoder read port: registered every cycle, returns old data on a same-address write
   always_ff @(posedge clk6 or posedge rst) begin
      if (rst) begin
         dec_rd_data <= '0;
      end else begin
         dec_rd_data <= cw_buf[dec_rd_addr];
      end
   end

endmodule
